// File: rtl/mod_recombine.sv
// mod_recombine: rebuilds a dividend from quotient, divisor and remainder,
// OUT = Q*Y + R (mod 2^WIDTH), by performing one addition of Y per clock.
//
// Ports:
//   CLK    clock, rising-edge active
//   RESET  asynchronous active-high reset
//   START  request: sample Q, Y, R and begin (ignored while BUSY)
//   Q      number of additions of Y
//   Y      addend
//   R      accumulator start value
//   OUT    accumulator; final result when READY=1
//   READY  result valid, held until the next accepted START
//   BUSY   additions in progress
//   OVF    sticky carry-out of any addition since the last accepted START
module mod_recombine #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] Q,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] OUT,
    output logic             READY,
    output logic             BUSY,
    output logic             OVF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] yr;
    logic             ovf;
    logic             accept_c;
    logic [WIDTH:0]   sum_c;

    // START is only honoured outside the run phase.
    assign accept_c = START && (state != S_RUN);

    // One extra bit captures the carry out of the accumulator.
    assign sum_c = {1'b0, acc} + {1'b0, yr};

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_nxt = (Q != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (cnt == WIDTH'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs decoded straight from the state flops.
    always_comb begin
        READY = 1'b0;
        BUSY  = 1'b0;
        case (state)
            S_RUN:   BUSY  = 1'b1;
            S_DONE:  READY = 1'b1;
            default: ;
        endcase
    end

    // Accumulator, remaining-count, latched addend and sticky overflow.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc <= '0;
            cnt <= '0;
            yr  <= '0;
            ovf <= 1'b0;
        end else if (accept_c) begin
            acc <= R;
            cnt <= Q;
            yr  <= Y;
            ovf <= 1'b0;
        end else if (state == S_RUN) begin
            acc <= sum_c[WIDTH-1:0];
            cnt <= cnt - WIDTH'(1);
            ovf <= ovf | sum_c[WIDTH];
        end
    end

    assign OUT = acc;
    assign OVF = ovf;

endmodule
